// File: rtl/vend_pkg.sv
// Shared types and constants for the parametrised vending controller.
package vend_pkg;

    typedef enum logic [1:0] {
        V_IDLE   = 2'd0,
        V_VEND   = 2'd1,
        V_CHANGE = 2'd2
    } vend_state_t;

    localparam int unsigned PROD_NONE    = 0;
    localparam int unsigned PROD_PEPSI   = 1;
    localparam int unsigned PROD_COCA    = 2;
    localparam int unsigned PROD_REDBULL = 3;

    localparam logic [3:0] PRICE_PEPSI   = 4'd1;
    localparam logic [3:0] PRICE_COCA    = 4'd2;
    localparam logic [3:0] PRICE_REDBULL = 4'd3;

endpackage

// File: rtl/vend_price_lut.sv
// Combinational product-code to price lookup, sliced from the packed price table.
module vend_price_lut #(
    parameter int unsigned CREDIT_W = 4,
    parameter int unsigned N_PROD   = 3,
    parameter logic [N_PROD*CREDIT_W-1:0] PRICE = {4'd3, 4'd2, 4'd1},
    parameter int unsigned SEL_W    = $clog2(N_PROD + 1)
) (
    input  logic [SEL_W-1:0]    sel,
    output logic [CREDIT_W-1:0] price,
    output logic                sel_in_range
);

    always_comb begin
        price        = '0;
        sel_in_range = (sel != '0) && (sel <= SEL_W'(N_PROD));
        // Code 0 and out-of-range codes fall through with price 0.
        for (int k = 1; k <= int'(N_PROD); k++) begin
            if (sel == SEL_W'(k)) begin
                price = PRICE[k*CREDIT_W-1 -: CREDIT_W];
            end
        end
    end

endmodule

// File: rtl/vend_ctrl_param.sv
// Vending controller: credit accumulation, priced selection, handshaked dispense
// and one-unit-per-handshake change return.
module vend_ctrl_param
    import vend_pkg::*;
#(
    parameter int unsigned CREDIT_W   = 4,
    parameter int unsigned MAX_CREDIT = 9,
    parameter int unsigned N_PROD     = 3,
    parameter logic [N_PROD*CREDIT_W-1:0] PRICE = {PRICE_REDBULL, PRICE_COCA, PRICE_PEPSI},
    localparam int unsigned SEL_W     = $clog2(N_PROD + 1)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                coin_valid,
    input  logic [CREDIT_W-1:0] coin_val,
    input  logic                sel_valid,
    input  logic [SEL_W-1:0]    sel,
    input  logic                cancel,
    input  logic                disp_ready,
    input  logic                change_ready,
    output logic                disp_valid,
    output logic [SEL_W-1:0]    disp_prod,
    output logic                change_valid,
    output logic [CREDIT_W-1:0] credit,
    output logic                coin_reject,
    output logic                sel_err,
    output logic                busy
);

    vend_state_t         state_q, state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic [SEL_W-1:0]    disp_prod_q, disp_prod_d;
    logic                coin_reject_q, coin_reject_d;
    logic                sel_err_q, sel_err_d;

    logic [CREDIT_W-1:0] price;
    logic                sel_in_range;
    logic [CREDIT_W:0]   coin_sum;
    logic                coin_fits;

    vend_price_lut #(
        .CREDIT_W (CREDIT_W),
        .N_PROD   (N_PROD),
        .PRICE    (PRICE),
        .SEL_W    (SEL_W)
    ) u_price_lut (
        .sel          (sel),
        .price        (price),
        .sel_in_range (sel_in_range)
    );

    // One extra bit so an oversized coin cannot wrap into an apparently valid credit.
    assign coin_sum  = {1'b0, credit_q} + {1'b0, coin_val};
    assign coin_fits = coin_sum <= (CREDIT_W+1)'(MAX_CREDIT);

    assign disp_valid   = (state_q == V_VEND);
    assign disp_prod    = disp_prod_q;
    assign change_valid = (state_q == V_CHANGE) && (credit_q != '0);
    assign credit       = credit_q;
    assign coin_reject  = coin_reject_q;
    assign sel_err      = sel_err_q;
    assign busy         = (state_q != V_IDLE);

    always_comb begin
        state_d       = state_q;
        credit_d      = credit_q;
        disp_prod_d   = disp_prod_q;
        coin_reject_d = 1'b0;
        sel_err_d     = 1'b0;
        unique case (state_q)
            V_IDLE: begin
                if (cancel) begin
                    coin_reject_d = coin_valid;
                    if (credit_q != '0) begin
                        state_d = V_CHANGE;
                    end
                end else if (sel_valid && sel_in_range && (credit_q >= price)) begin
                    coin_reject_d = coin_valid;
                    disp_prod_d   = sel;
                    credit_d      = credit_q - price;
                    state_d       = V_VEND;
                end else begin
                    // A refused selection still lets a same-cycle coin through.
                    sel_err_d = sel_valid && (sel != '0);
                    if (coin_valid) begin
                        if (coin_fits) begin
                            credit_d = coin_sum[CREDIT_W-1:0];
                        end else begin
                            coin_reject_d = 1'b1;
                        end
                    end
                end
            end
            V_VEND: begin
                coin_reject_d = coin_valid;
                if (disp_ready) begin
                    disp_prod_d = '0;
                    state_d     = (credit_q != '0) ? V_CHANGE : V_IDLE;
                end
            end
            V_CHANGE: begin
                coin_reject_d = coin_valid;
                if (credit_q == '0) begin
                    state_d = V_IDLE;
                end else if (change_ready) begin
                    credit_d = credit_q - CREDIT_W'(1);
                    if (credit_q == CREDIT_W'(1)) begin
                        state_d = V_IDLE;
                    end
                end
            end
            default: begin
                state_d = V_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= V_IDLE;
            credit_q      <= '0;
            disp_prod_q   <= '0;
            coin_reject_q <= 1'b0;
            sel_err_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            credit_q      <= credit_d;
            disp_prod_q   <= disp_prod_d;
            coin_reject_q <= coin_reject_d;
            sel_err_q     <= sel_err_d;
        end
    end

endmodule

// File: doc/vend_ctrl_param.md
Name: vend_ctrl_param

Overview:
Parametrised vending-machine controller that generalises the 4-state fixed credit/product Mealy FSM.
- Accumulates variable-value coins into a bounded credit register and checks selections against a parameter price table.
- Dispenses through a valid/ready handshake to the dispenser, then returns change one unit per handshake.
- Sits between the coin/keypad input conditioning and the dispenser/change-hopper drivers on the Basys 3 top.

Parameters:
- CREDIT_W, 4, width of credit and coin value.
- MAX_CREDIT, 9, highest credit held; must be < 2**CREDIT_W.
- N_PROD, 3, number of products; codes 1..N_PROD, code 0 = none.
- PRICE, {4'd3,4'd2,4'd1}, packed N_PROD*CREDIT_W vector; price of product k at bits [k*CREDIT_W-1 -: CREDIT_W].
- SEL_W (localparam), $clog2(N_PROD+1), selection code width (2 at default).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous active-high reset
- coin_valid  in  1  coin present this cycle
- coin_val  in  CREDIT_W  coin value in credit units
- sel_valid  in  1  selection strobe
- sel  in  SEL_W  product code
- cancel  in  1  refund request
- disp_ready  in  1  dispenser accepts product
- change_ready  in  1  hopper accepts one change unit
- disp_valid  out  1  product request pending
- disp_prod  out  SEL_W  product being dispensed
- change_valid  out  1  one change unit offered
- credit  out  CREDIT_W  current credit (registered)
- coin_reject  out  1  one-cycle pulse, coin refused
- sel_err  out  1  one-cycle pulse, selection refused
- busy  out  1  state != V_IDLE

Behaviour:
- Reset is asynchronous, active-high; clock is clk.
- Reset values: state V_IDLE, credit 0, disp_prod 0, all pulse/valid outputs 0.
- Reset mid-operation aborts any vend or change immediately; credit is lost.
- States: V_IDLE, V_VEND, V_CHANGE. disp_valid, disp_prod, change_valid and busy decode from state/registers (Moore). coin_reject and sel_err are registered, high the cycle after the event.
- V_IDLE, priority cancel > select > coin, evaluated on the current (pre-update) credit:
  - cancel: credit>0 -> V_CHANGE; credit==0 -> stay.
  - Any coin_valid in the same cycle as cancel -> coin_reject.
  - sel_valid, sel in 1..N_PROD, credit >= PRICE[sel]: latch disp_prod=sel, credit <= credit-PRICE[sel], -> V_VEND.
  - Any coin_valid in the same cycle as an accepted selection -> coin_reject.
  - sel_valid with sel==0: ignored, no error.
  - sel_valid with sel>N_PROD or credit<PRICE[sel]: sel_err, stay.
  - A coin in the same cycle as a refused selection is still processed.
  - Coin: credit+coin_val <= MAX_CREDIT -> credit += coin_val, next cycle. Otherwise coin_reject, credit unchanged. The sum is computed at CREDIT_W+1 bits, so no wrap.
  - coin_val==0 is accepted as a no-op.
- V_VEND:
  - disp_valid=1; disp_prod held stable until the transfer.
  - Transfer on disp_valid & disp_ready. Then credit>0 -> V_CHANGE, else -> V_IDLE.
  - cancel and sel_valid are ignored. coin_valid -> coin_reject.
- V_CHANGE:
  - change_valid=1.
  - On change_valid & change_ready: credit--. A handshake at credit==1 -> V_IDLE the next cycle.
  - change_valid never asserts with credit==0.
  - Coins rejected, selections ignored, cancel ignored.
- Zero-price product is legal: vends with credit 0.
- Latency:
  - Coin to credit update: 1 cycle.
  - Accepted selection to disp_valid: 1 cycle.
  - disp_ready handshake to change_valid: 1 cycle.

Decomposition:
- Package vend_pkg:
  - typedef enum vend_state_t {V_IDLE, V_VEND, V_CHANGE}.
  - Product code constants PROD_NONE=0, PROD_PEPSI=1, PROD_COCA=2, PROD_REDBULL=3.
  - Default price constants.
- One sub-module: vend_price_lut. Combinational sel -> price plus sel_in_range flag, sliced from PRICE.
- FSM, credit register and pulse registers stay in the top.

Test Plan (defaults):
- Reset, then coins 1,2 on consecutive cycles -> credit 1 then 3. Select sel=2 -> disp_valid=1, disp_prod=2, credit=1. disp_ready after 2 cycles -> change_valid one handshake, credit 0, busy 0.
- credit=8, coin_val=2 -> coin_reject pulse 1 cycle, credit stays 8. coin_val=1 -> credit 9.
- credit=1, sel=3 -> sel_err pulse, state V_IDLE. sel=0 -> no sel_err.
- credit=4, cancel + sel=1 + coin=1 same cycle -> V_CHANGE, coin_reject. With change_ready toggling 1,0,1,1,1 -> credit 3,3,2,1,0 -> V_IDLE.
- credit=2, sel=1 + coin=2 same cycle -> vend, coin_reject, credit=1. disp_ready held 0 for 5 cycles -> disp_valid and disp_prod stable throughout.
- Assert reset in V_VEND and again in V_CHANGE -> all outputs 0 asynchronously (before next clk), credit 0.
